ucode_loader: RTL and testbench

- Writer side of the microcode instruction format: accepts a narrow byte stream from the configuration path and packs each group of beats into one full-width microcode instruction.
- Writes each packed instruction into the sequencer's ucode memory, which the ucode decoder later reads.
- One load session writes a programmed number of consecutive instructions from a programmed start address.

---
 rtl/ucode_loader.sv | 176 +++++++++++++++++
 tb/tb_ucode_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_loader.sv
// Packs a narrow configuration byte stream into full-width microcode words and writes them to ucode memory.
// Optional RISC opcode range check is enabled with `define UCODE_LOADER_OPCODE_CHECK_EN.
module ucode_loader #(
  parameter int INSTR_WIDTH = 26,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [ADDR_WIDTH:0]    num_instr_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [INSTR_WIDTH-1:0] mem_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ADDR_WIDTH:0]    instr_count_o
);

  localparam int NBEATS = (INSTR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] buf_q;
  logic [INSTR_WIDTH-1:0] last_wdata_q;
  logic [BCNT_W-1:0]      beat_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  last_addr_q;
  logic [CNT_W-1:0]       remaining_q;
  logic [CNT_W-1:0]       count_q;
  logic                   last_beat;
  logic                   word_bad;

  assign last_beat = (beat_q == BCNT_W'(NBEATS - 1));

`ifdef UCODE_LOADER_OPCODE_CHECK_EN
  // RISC opcodes above SET_MAN_VALUE (17) are undefined; NISC words bypass the check.
  assign word_bad = !buf_q[INSTR_WIDTH-1] && (buf_q[INSTR_WIDTH-2 -: 5] > 5'd17);
`else
  assign word_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    mem_we_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_instr_i == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        busy_o       = 1'b1;
        data_ready_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (data_valid_i && last_beat) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          mem_we_o = !word_bad;
          state_d  = (remaining_q == CNT_W'(1)) ? DONE : COLLECT;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat packing, session bookkeeping and the last-written memory image.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      count_q      <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q      <= start_addr_i;
            remaining_q <= num_instr_i;
            count_q     <= '0;
            beat_q      <= '0;
          end
        end
        COLLECT: begin
          if (abort_i) begin
            beat_q <= '0;
          end else if (data_valid_i) begin
            // Bits of the final beat beyond INSTR_WIDTH have no slot and fall away here.
            for (int i = 0; i < INSTR_WIDTH; i++) begin
              if (beat_q == BCNT_W'(i / DATA_WIDTH)) begin
                buf_q[i] <= data_i[i % DATA_WIDTH];
              end
            end
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
          end
        end
        WRITE: begin
          beat_q <= '0;
          if (!abort_i) begin
            remaining_q <= remaining_q - 1'b1;
            count_q     <= count_q + 1'b1;
            if (mem_we_o) begin
              addr_q       <= addr_q + 1'b1;
              last_addr_q  <= addr_q;
              last_wdata_q <= buf_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UCODE_LOADER_OPCODE_CHECK_EN
  logic error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      error_q <= 1'b0;
    end else if (state_q == WRITE && !abort_i && word_bad) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  // The memory bus shows the live word only during WRITE, otherwise the last committed one.
  assign mem_addr_o    = (state_q == WRITE) ? addr_q : last_addr_q;
  assign mem_wdata_o   = (state_q == WRITE) ? buf_q : last_wdata_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: directed scenarios plus randomized sessions checked
// against a word-level model of the expected memory writes.
module tb_ucode_loader;

  localparam int IW = 26;
  localparam int DW = 8;
  localparam int AW = 10;

`ifdef UCODE_LOADER_OPCODE_CHECK_EN
  localparam bit OPC_CHECK = 1'b1;
`else
  localparam bit OPC_CHECK = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] start_addr_i;
  logic [AW:0]   num_instr_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [AW:0]   instr_count_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [AW+IW-1:0] obs_q[$];
  logic [AW+IW-1:0] exp_q[$];
  logic [IW-1:0]    word_q[$];

  ucode_loader dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .start_addr_i (start_addr_i),
    .num_instr_i  (num_instr_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .instr_count_o(instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every write strobe and completion pulse away from the active edge.
  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) obs_q.push_back({mem_addr_o, mem_wdata_o});
    if (done_o === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic bit is_bad(input logic [IW-1:0] w);
    return OPC_CHECK && !w[IW-1] && (w[IW-2 -: 5] > 5'd17);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] b);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    data_i = b;
    data_valid_i = 1'b1;
    while (!acc && guard < 40) begin
      @(negedge clk_i);
      acc = data_ready_o;
      step();
      guard++;
    end
    data_valid_i = 1'b0;
    data_i = 8'($urandom);
    checkOutput("beat_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [IW-1:0] w, input bit gaps, input bit fixed_junk, input bit mid_start);
    logic [5:0] junk;
    logic [DW-1:0] b;
    for (int k = 0; k < 4; k++) begin
      if (mid_start && k == 1) begin
        start_i = 1'b1;
        start_addr_i = AW'($urandom);
        num_instr_i = 11'($urandom_range(0, 9));
        step();
        start_i = 1'b0;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step();
      end
      junk = fixed_junk ? 6'h3F : 6'($urandom);
      b = (k == 3) ? {junk, w[25:24]} : 8'(w >> (8 * k));
      send_beat(b);
    end
  endtask

  task automatic start_session(input logic [AW-1:0] saddr, input int n);
    obs_q.delete();
    done_cnt = 0;
    start_i = 1'b1;
    start_addr_i = saddr;
    num_instr_i = 11'(n);
    step();
    start_i = 1'b0;
    start_addr_i = AW'($urandom);
    num_instr_i = 11'($urandom);
  endtask

  // Runs one complete session over word_q and compares against the word-level model.
  task automatic applyStimulus(input logic [AW-1:0] saddr, input bit gaps, input bit fixed_junk, input bit mid_start);
    logic [AW-1:0] a;
    logic [AW+IW-1:0] last;
    bit err;
    int n;
    n = word_q.size();
    exp_q.delete();
    a = saddr;
    err = 1'b0;
    foreach (word_q[i]) begin
      if (is_bad(word_q[i])) begin
        err = 1'b1;
      end else begin
        exp_q.push_back({a, word_q[i]});
        a = a + 1'b1;
      end
    end
    start_session(saddr, n);
    foreach (word_q[i]) send_word(word_q[i], gaps, fixed_junk, mid_start && i == 0);
    for (int c = 0; c < 12 && done_cnt == 0; c++) begin
      @(posedge clk_i);
      #2;
    end
    checkOutput("done_once", 64'(done_cnt), 64'd1);
    checkOutput("instr_count", 64'(instr_count_o), 64'(n));
    checkOutput("error", 64'(error_o), 64'(err));
    checkOutput("busy_end", 64'(busy_o), 64'd0);
    checkOutput("nwrites", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("write%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
    if (exp_q.size() > 0) begin
      last = exp_q[exp_q.size() - 1];
      checkOutput("hold_addr", 64'(mem_addr_o), 64'(last[AW+IW-1:IW]));
      checkOutput("hold_data", 64'(mem_wdata_o), 64'(last[IW-1:0]));
    end
  endtask

  initial begin
    logic [IW-1:0] w;
    logic [AW-1:0] saddr;
    int n;
    rst_ni = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    start_addr_i = '0;
    num_instr_i = '0;
    data_i = '0;
    data_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_ready", 64'(data_ready_o), 64'd0);
    checkOutput("rst_we", 64'(mem_we_o), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_error", 64'(error_o), 64'd0);
    checkOutput("rst_count", 64'(instr_count_o), 64'd0);
    rst_ni = 1'b1;
    step();

    $display("[TB] directed RISC JMP write");
    start_session(10'd5, 1);
    send_beat(8'h23);
    send_beat(8'h01);
    send_beat(8'h20);
    send_beat(8'h00);
    @(negedge clk_i);
    checkOutput("jmp_we", 64'(mem_we_o), 64'd1);
    checkOutput("jmp_addr", 64'(mem_addr_o), 64'd5);
    checkOutput("jmp_data", 64'(mem_wdata_o), 64'h0200123);
    checkOutput("jmp_ready_write", 64'(data_ready_o), 64'd0);
    step();
    @(negedge clk_i);
    checkOutput("jmp_done", 64'(done_o), 64'd1);
    checkOutput("jmp_we_after", 64'(mem_we_o), 64'd0);
    checkOutput("jmp_count", 64'(instr_count_o), 64'd1);
    step();
    @(negedge clk_i);
    checkOutput("jmp_done_pulse", 64'(done_o), 64'd0);
    checkOutput("jmp_nwrites", 64'(obs_q.size()), 64'd1);
    step();

    $display("[TB] zero-length session");
    start_session(10'd77, 0);
    @(negedge clk_i);
    checkOutput("zero_done", 64'(done_o), 64'd1);
    checkOutput("zero_busy", 64'(busy_o), 64'd0);
    step();
    checkOutput("zero_nwrites", 64'(obs_q.size()), 64'd0);
    word_q.delete();
    applyStimulus(10'd300, 1'b0, 1'b0, 1'b0);

    $display("[TB] wrap and NISC with junk top bits");
    word_q = '{26'h2ABCDEF, 26'h0000000};
    applyStimulus(10'd1023, 1'b0, 1'b1, 1'b0);

    $display("[TB] backpressure gaps and ignored start");
    word_q = '{26'h0123456};
    applyStimulus(10'd40, 1'b1, 1'b0, 1'b0);
    word_q = '{26'h2000001, 26'h3FFFFFF, 26'h0011111};
    applyStimulus(10'd200, 1'b1, 1'b0, 1'b1);

    $display("[TB] opcode range check");
    word_q = '{26'h1F00000, 26'h0200001};
    applyStimulus(10'd8, 1'b0, 1'b0, 1'b0);

    $display("[TB] abort mid-collect");
    saddr = AW'($urandom);
    start_session(saddr, 3);
    send_word(26'h2000AAA, 1'b0, 1'b0, 1'b0);
    send_beat(8'h11);
    send_beat(8'h22);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    repeat (3) step();
    checkOutput("abort_nwrites", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) checkOutput("abort_write0", 64'(obs_q[0]), 64'({saddr, 26'h2000AAA}));
    checkOutput("abort_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_count", 64'(instr_count_o), 64'd1);
    checkOutput("abort_busy", 64'(busy_o), 64'd0);

    $display("[TB] abort in write cycle");
    start_session(10'd600, 2);
    send_word(26'h2555555, 1'b0, 1'b0, 1'b0);
    abort_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abortw_we", 64'(mem_we_o), 64'd0);
    step();
    abort_i = 1'b0;
    repeat (2) step();
    checkOutput("abortw_nwrites", 64'(obs_q.size()), 64'd0);
    checkOutput("abortw_count", 64'(instr_count_o), 64'd0);
    checkOutput("abortw_done", 64'(done_cnt), 64'd0);
    checkOutput("abortw_busy", 64'(busy_o), 64'd0);

    $display("[TB] reset mid-session");
    start_session(10'd100, 2);
    send_beat(8'h5A);
    send_beat(8'hA5);
    rst_ni = 1'b0;
    #1;
    checkOutput("mrst_busy", 64'(busy_o), 64'd0);
    checkOutput("mrst_ready", 64'(data_ready_o), 64'd0);
    checkOutput("mrst_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("mrst_wdata", 64'(mem_wdata_o), 64'd0);
    checkOutput("mrst_count", 64'(instr_count_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step();
    checkOutput("mrst_nwrites", 64'(obs_q.size()), 64'd0);
    checkOutput("mrst_busy_after", 64'(busy_o), 64'd0);

    $display("[TB] randomized sessions");
    for (int s = 0; s < 12; s++) begin
      word_q.delete();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        w = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 20'($urandom)};
        word_q.push_back(w);
      end
      saddr = ($urandom_range(0, 2) == 0) ? AW'(1023 - $urandom_range(0, 2)) : AW'($urandom);
      applyStimulus(saddr, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
